// File: rtl/uart_pkg.sv
// ============================================================================
// Package    : uart_pkg
// Description: Shared UART types and constants (FSM states, line levels,
//              baud select codes common to the baud controller).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic TXD_START = 1'b0;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Baud select codes decoded by the baud controller.
  localparam logic [1:0] BAUD_SEL_9600   = 2'd0;
  localparam logic [1:0] BAUD_SEL_19200  = 2'd1;
  localparam logic [1:0] BAUD_SEL_57600  = 2'd2;
  localparam logic [1:0] BAUD_SEL_115200 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/uart_tx_controller_if.sv
// ============================================================================
// Interface  : uart_tx_controller_if
// Description: Host write / serial-side bundle of the UART transmitter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_controller_if #(
  parameter int DATA_BITS = 8
);

  logic                 sample_ENABLE;
  logic                 Tx_EN;
  logic                 Tx_WR;
  logic [DATA_BITS-1:0] Tx_DATA;
  logic                 TxD;
  logic                 Tx_BUSY;
  logic                 Tx_DONE;

  modport master (
    output sample_ENABLE, Tx_EN, Tx_WR, Tx_DATA,
    input  TxD, Tx_BUSY, Tx_DONE
  );

  modport slave (
    input  sample_ENABLE, Tx_EN, Tx_WR, Tx_DATA,
    output TxD, Tx_BUSY, Tx_DONE
  );

endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module     : uart_bit_timer
// Description: Counts oversample strobes per serial bit; pulses bit_end on
//              the OVERSAMPLE-th strobe. Synchronous clear has priority.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample_enable,
  output logic bit_end
);

  localparam int              C_CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(OVERSAMPLE - 1);

  logic [C_CW-1:0] r_count;
  logic            w_last;

  assign w_last  = (r_count == C_LAST);
  // A strobe arriving while cleared is dropped, not counted.
  assign bit_end = sample_enable && !clear && w_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (sample_enable) begin
      r_count <= w_last ? '0 : r_count + C_CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_controller.sv
// ============================================================================
// Module     : uart_tx_controller
// Description: UART transmit sequencer: start, DATA_BITS LSB-first, optional
//              even parity (macro UART_TX_PARITY_EN), one stop bit.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_controller_if.slave bus
);

  localparam int            C_IW       = $clog2(DATA_BITS + 1);
  localparam logic [C_IW-1:0] C_LAST_IDX = C_IW'(DATA_BITS - 1);

  tx_state_t            r_state,   w_state_next;
  logic [C_IW-1:0]      r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shreg,   w_shreg_next;
  logic                 r_txd,     w_txd_next;
  logic                 r_busy;
  logic                 r_done,    w_done_next;
  logic                 w_accept;
  logic                 w_timer_clear;
  logic                 w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Held in clear while idle so a frame always starts from a zero count.
  assign w_timer_clear = (r_state == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk           (clk),
    .reset         (reset),
    .clear         (w_timer_clear),
    .sample_enable (bus.sample_ENABLE),
    .bit_end       (w_bit_end)
  );

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    w_done_next    = 1'b0;
    w_accept       = 1'b0;
    w_txd_next     = TXD_IDLE;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.Tx_EN && bus.Tx_WR) begin
          w_accept       = 1'b1;
          w_state_next   = ST_START;
          w_bit_idx_next = '0;
          w_shreg_next   = bus.Tx_DATA;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          // Shifting keeps the current data bit at position 0.
          w_shreg_next = r_shreg >> 1;
          if (r_bit_idx == C_LAST_IDX) begin
            w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next   = ST_PARITY;
`else
            w_state_next   = ST_STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + C_IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    unique case (w_state_next)
      ST_START:  w_txd_next = TXD_START;
      ST_DATA:   w_txd_next = w_shreg_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_txd_next = r_parity;
`endif
      default:   w_txd_next = TXD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_txd     <= TXD_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_shreg   <= w_shreg_next;
      r_txd     <= w_txd_next;
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= w_done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as latched, since the shifter consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^bus.Tx_DATA;
    end
  end
`endif

  assign bus.TxD     = r_txd;
  assign bus.Tx_BUSY = r_busy;
  assign bus.Tx_DONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_controller.sv
// ============================================================================
// Module     : tb_uart_tx_controller
// Description: Scoreboard bench for uart_tx_controller (honours the
//              UART_TX_PARITY_EN macro for frame length).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_controller;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_tx_controller_if #(.DATA_BITS(DB)) bus ();

  uart_tx_controller #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] exp_q[$];
  bit  model_busy  = 1'b0;
  int  model_cnt   = 0;
  int  strobe_mode = 2;
  int  phase       = 0;

  bit  mon_active  = 1'b0;
  bit  prev_busy   = 1'b0;
  int  mon_cnt     = 0;
  int  busy_len    = 0;
  int  last_busy_len = 0;
  int  frames_done = 0;
  bit  wave_bad    = 1'b0;
  bit  done_bad    = 1'b0;
  bit  idle_txd_bad = 1'b0;
  logic [NBITS-1:0] cur_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected serial frame, bit 0 first on the line.
  function automatic logic [NBITS-1:0] frame_of(input logic [DB-1:0] d);
    logic [NBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    f[DB+1] = ^d;
`endif
    return f;
  endfunction

  // One clock of stimulus; the model tracks frames as strobe counts.
  task automatic step(input bit en, input bit wr, input logic [DB-1:0] data);
    bit stb;
    case (strobe_mode)
      0:       stb = (phase == 0);
      1:       stb = ($urandom_range(0, 2) == 0);
      default: stb = 1'b0;
    endcase
    phase = (phase + 1) % 4;
    bus.sample_ENABLE = stb;
    bus.Tx_EN         = en;
    bus.Tx_WR         = wr;
    bus.Tx_DATA       = data;
    if (reset) begin
      model_busy = 1'b0;
      model_cnt  = 0;
      exp_q.delete();
    end else if (!model_busy && en && wr) begin
      exp_q.push_back(data);
      model_busy = 1'b1;
      model_cnt  = 0;
    end else if (model_busy && stb) begin
      model_cnt++;
      if (model_cnt == NBITS * OS) model_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (model_busy && n < 20000) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    if (model_busy) check("idle_timeout", 32'd1, 32'd0);
    repeat (3) step(1'b0, 1'b0, '0);
  endtask

  task automatic run_until_cnt(input int target);
    int n;
    n = 0;
    while (model_busy && model_cnt < target && n < 20000) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    if (n >= 20000) check("cnt_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: decodes the line against the popped frame each busy cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (bus.Tx_BUSY && !prev_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            mon_active = 1'b0;
          end else begin
            cur_frame  = frame_of(exp_q.pop_front());
            mon_active = 1'b1;
            mon_cnt    = 0;
            busy_len   = 0;
            wave_bad   = 1'b0;
          end
        end
        if (bus.Tx_BUSY) begin
          if (bus.Tx_DONE) done_bad = 1'b1;
          if (mon_active) begin
            busy_len++;
            if (mon_cnt >= NBITS * OS) wave_bad = 1'b1;
            else if (bus.TxD !== cur_frame[mon_cnt / OS]) wave_bad = 1'b1;
            if (bus.sample_ENABLE) mon_cnt++;
          end
        end else begin
          if (prev_busy && mon_active) begin
            check("frame_txd", {31'd0, wave_bad}, 32'd0);
            check("frame_strobes", mon_cnt, NBITS * OS);
            check("done_pulse", {31'd0, bus.Tx_DONE}, 32'd1);
            last_busy_len = busy_len;
            frames_done++;
            mon_active = 1'b0;
          end else if (bus.Tx_DONE) begin
            done_bad = 1'b1;
          end
          if (bus.TxD !== 1'b1) idle_txd_bad = 1'b1;
        end
        prev_busy = bus.Tx_BUSY;
      end
    end
  end

  initial begin
    bus.sample_ENABLE = 1'b0;
    bus.Tx_EN         = 1'b0;
    bus.Tx_WR         = 1'b0;
    bus.Tx_DATA       = '0;
    strobe_mode       = 2;
    repeat (3) step(1'b0, 1'b0, '0);
    check("reset_txd",  {31'd0, bus.TxD},     32'd1);
    check("reset_busy", {31'd0, bus.Tx_BUSY}, 32'd0);
    check("reset_done", {31'd0, bus.Tx_DONE}, 32'd0);
    reset = 1'b0;
    repeat (2) step(1'b0, 1'b0, '0);

    // A5 with strobe every 4 clocks; the accept cycle carries a strobe.
    strobe_mode = 0;
    while (phase != 0) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 8'hA5);
    check("start_latency_busy", {31'd0, bus.Tx_BUSY}, 32'd1);
    check("start_latency_txd",  {31'd0, bus.TxD},     32'd0);
    wait_idle();
    check("busy_len", last_busy_len, NBITS * OS * 4);

    // Back-to-back FF then 3C; a mid-frame 00 write must be ignored.
    step(1'b1, 1'b1, 8'hFF);
    repeat (OS * 4 * 3) step(1'b1, 1'b1, 8'h00);
    run_until_cnt(NBITS * OS);
    step(1'b1, 1'b1, 8'h3C);
    check("b2b_busy", {31'd0, bus.Tx_BUSY}, 32'd1);
    wait_idle();

    // Writes with the enable low are dropped.
    repeat (20) step(1'b0, 1'b1, DB'($urandom));
    check("en_low_txd",  {31'd0, bus.TxD},     32'd1);
    check("en_low_busy", {31'd0, bus.Tx_BUSY}, 32'd0);

    // Enable dropped mid-frame: frame still completes.
    step(1'b1, 1'b1, 8'h5A);
    repeat (300) step(1'b0, 1'b0, '0);
    wait_idle();

    // Reset during data bit 3, then a clean 81 frame.
    step(1'b1, 1'b1, DB'($urandom));
    run_until_cnt(OS * 4 + 5);
    reset = 1'b1;
    step(1'b0, 1'b0, '0);
    reset = 1'b0;
    check("midreset_txd",  {31'd0, bus.TxD},     32'd1);
    check("midreset_busy", {31'd0, bus.Tx_BUSY}, 32'd0);
    check("midreset_done", {31'd0, bus.Tx_DONE}, 32'd0);
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 8'h81);
    wait_idle();

    // Strobes withheld for 100 clocks mid-bit.
    strobe_mode = 1;
    step(1'b1, 1'b1, DB'($urandom));
    run_until_cnt(OS * 2 + 3);
    strobe_mode = 2;
    repeat (100) step(1'b0, 1'b0, '0);
    strobe_mode = 1;
    wait_idle();

    // Random traffic: sporadic strobes, enables and writes.
    repeat (8000) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), DB'($urandom));
    wait_idle();

    check("queue_empty", exp_q.size(), 32'd0);
    check("stray_done", {31'd0, done_bad}, 32'd0);
    check("idle_txd", {31'd0, idle_txd_bad}, 32'd0);
    check("frames_seen_min", {31'd0, (frames_done >= 8)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
